control_multiciclo: RTL and testbench

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

---
 rtl/control_multiciclo.sv | 193 +++++++++++++++++++
 tb/tb_control_multiciclo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// -----------------------------------------------------------------------------
// control_multiciclo
//
// Main control unit of a multicycle MIPS-style datapath. A single FSM walks
// each instruction through fetch, decode and the per-class execute/write-back
// states, driving the datapath select and write-enable lines from the current
// state. MemListo stretches the memory states until the access completes.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (forces INICIO immediately)
//   instru[5:0]  opcode field from the instruction register
//   MemListo     memory ready, completes the current memory access
//   EscrPC       unconditional PC write
//   EscrPCCond   PC write, qualified outside by the ALU zero flag
//   IoD          memory address select: 0=PC, 1=ALUOut
//   LeerMem      memory read
//   EscrMem      memory write
//   EscrIR       instruction register write
//   MemaReg      register write data select: 1=MDR, 0=ALUOut
//   RegDest      destination register select: 1=rd, 0=rt
//   EscrReg      register file write
//   FuenteALUA   ALU A select: 0=PC, 1=rs
//   FuenteALUB   ALU B select: 00=rt, 01=4, 10=signext, 11=signext<<2
//   ALUOp        00=add, 01=sub, 10=funct
//   FuentePC     PC source: 00=ALU, 01=ALUOut, 10=jump target
//   InstrIlegal  one-cycle pulse in DECOD on an unsupported opcode
//   Estado[3:0]  current state code
//
// Build option:
//   CONTROL_SALTO_J_EN  when defined, opcode 000010 (j) goes DECOD->BRINCO.
//                       When undefined, j is illegal and code 10 is unused.
// -----------------------------------------------------------------------------
module control_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] instru,
  input  logic       MemListo,
  output logic       EscrPC,
  output logic       EscrPCCond,
  output logic       IoD,
  output logic       LeerMem,
  output logic       EscrMem,
  output logic       EscrIR,
  output logic       MemaReg,
  output logic       RegDest,
  output logic       EscrReg,
  output logic       FuenteALUA,
  output logic [1:0] FuenteALUB,
  output logic [1:0] ALUOp,
  output logic [1:0] FuentePC,
  output logic       InstrIlegal,
  output logic [3:0] Estado
);

  typedef enum logic [3:0] {
    INICIO     = 4'd0,
    BUSQUEDA   = 4'd1,
    DECOD      = 4'd2,
    DIRMEM     = 4'd3,
    LEERMEM    = 4'd4,
    ESCRREGMEM = 4'd5,
    ESCRMEM    = 4'd6,
    EJEC       = 4'd7,
    FINR       = 4'd8,
    SALTO      = 4'd9,
    BRINCO     = 4'd10
  } estado_t;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef CONTROL_SALTO_J_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  estado_t estado_q, estado_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= INICIO;
    else        estado_q <= estado_d;
  end

  // NOTE: every output and the next state get a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    estado_d    = INICIO;  // unused codes fall back to INICIO
    EscrPC      = 1'b0;
    EscrPCCond  = 1'b0;
    IoD         = 1'b0;
    LeerMem     = 1'b0;
    EscrMem     = 1'b0;
    EscrIR      = 1'b0;
    MemaReg     = 1'b0;
    RegDest     = 1'b0;
    EscrReg     = 1'b0;
    FuenteALUA  = 1'b0;
    FuenteALUB  = 2'b00;
    ALUOp       = 2'b00;
    FuentePC    = 2'b00;
    InstrIlegal = 1'b0;

    case (estado_q)
      INICIO: estado_d = BUSQUEDA;

      BUSQUEDA: begin
        // PC+4 and IR load happen only on the cycle the fetch completes.
        LeerMem    = 1'b1;
        FuenteALUB = 2'b01;
        EscrIR     = MemListo;
        EscrPC     = MemListo;
        estado_d   = MemListo ? DECOD : BUSQUEDA;
      end

      DECOD: begin
        // Branch target precomputed into ALUOut: PC + (signext << 2).
        FuenteALUB = 2'b11;
        case (instru)
          OP_LW, OP_SW: estado_d = DIRMEM;
          OP_R:         estado_d = EJEC;
          OP_BEQ:       estado_d = SALTO;
`ifdef CONTROL_SALTO_J_EN
          OP_J:         estado_d = BRINCO;
`endif
          default: begin
            estado_d    = BUSQUEDA;
            InstrIlegal = 1'b1;
          end
        endcase
      end

      DIRMEM: begin
        FuenteALUA = 1'b1;
        FuenteALUB = 2'b10;
        estado_d   = (instru == OP_LW) ? LEERMEM : ESCRMEM;
      end

      LEERMEM: begin
        LeerMem  = 1'b1;
        IoD      = 1'b1;
        estado_d = MemListo ? ESCRREGMEM : LEERMEM;
      end

      ESCRREGMEM: begin
        EscrReg  = 1'b1;
        MemaReg  = 1'b1;
        estado_d = BUSQUEDA;
      end

      ESCRMEM: begin
        EscrMem  = 1'b1;
        IoD      = 1'b1;
        estado_d = MemListo ? BUSQUEDA : ESCRMEM;
      end

      EJEC: begin
        FuenteALUA = 1'b1;
        ALUOp      = 2'b10;
        estado_d   = FINR;
      end

      FINR: begin
        EscrReg  = 1'b1;
        RegDest  = 1'b1;
        estado_d = BUSQUEDA;
      end

      SALTO: begin
        FuenteALUA = 1'b1;
        ALUOp      = 2'b01;
        EscrPCCond = 1'b1;
        FuentePC   = 2'b01;
        estado_d   = BUSQUEDA;
      end

`ifdef CONTROL_SALTO_J_EN
      BRINCO: begin
        EscrPC   = 1'b1;
        FuentePC = 2'b10;
        estado_d = BUSQUEDA;
      end
`endif

      default: estado_d = INICIO;
    endcase
  end

  assign Estado = estado_q;

endmodule

// File: tb/tb_control_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_control_multiciclo
//
// Self-checking bench for control_multiciclo. A per-cycle table gives the
// inputs and the state the FSM must be in during that cycle; the expected
// outputs for that state come from a reference decode of the control table.
// Expected records are queued when a cycle is driven and popped/compared at
// the following falling edge. Hand-written sequences cover reset during a
// memory wait and the release timing.
// -----------------------------------------------------------------------------
module tb_control_multiciclo;

  logic       clk;
  logic       rst_n;
  logic [5:0] instru;
  logic       MemListo;
  logic       EscrPC, EscrPCCond, IoD, LeerMem, EscrMem, EscrIR;
  logic       MemaReg, RegDest, EscrReg, FuenteALUA, InstrIlegal;
  logic [1:0] FuenteALUB, ALUOp, FuentePC;
  logic [3:0] Estado;

  control_multiciclo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instru      (instru),
    .MemListo    (MemListo),
    .EscrPC      (EscrPC),
    .EscrPCCond  (EscrPCCond),
    .IoD         (IoD),
    .LeerMem     (LeerMem),
    .EscrMem     (EscrMem),
    .EscrIR      (EscrIR),
    .MemaReg     (MemaReg),
    .RegDest     (RegDest),
    .EscrReg     (EscrReg),
    .FuenteALUA  (FuenteALUA),
    .FuenteALUB  (FuenteALUB),
    .ALUOp       (ALUOp),
    .FuentePC    (FuentePC),
    .InstrIlegal (InstrIlegal),
    .Estado      (Estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {EscrPC, EscrPCCond, IoD, LeerMem, EscrMem, EscrIR, MemaReg, RegDest,
  //  EscrReg, FuenteALUA, FuenteALUB[1:0], ALUOp[1:0], FuentePC[1:0], InstrIlegal}
  logic [16:0] dut_outs;
  assign dut_outs = {EscrPC, EscrPCCond, IoD, LeerMem, EscrMem, EscrIR,
                     MemaReg, RegDest, EscrReg, FuenteALUA, FuenteALUB,
                     ALUOp, FuentePC, InstrIlegal};

  typedef struct {
    logic [5:0] instru;
    logic       ml;
    logic [3:0] est;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  est;
    logic [16:0] outs;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [5:0] i, input logic m, input logic [3:0] e);
    vec_t v;
    v.instru = i;
    v.ml     = m;
    v.est    = e;
    vecs.push_back(v);
  endtask

  // Reference decode of the control table for one state.
  function automatic logic [16:0] model_outs(input logic [3:0] st, input logic ml,
                                             input logic [5:0] op);
    logic pc, pcc, iod, rd, wr, ir, m2r, rdst, wreg, a, ilg;
    logic [1:0] b, aop, psrc;
    {pc, pcc, iod, rd, wr, ir, m2r, rdst, wreg, a, ilg} = '0;
    b = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd1: begin rd = 1'b1; b = 2'b01; ir = ml; pc = ml; end
      4'd2: begin
        b = 2'b11;
        ilg = !(op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
`ifdef CONTROL_SALTO_J_EN
                op == 6'b000010 ||
`endif
                op == 6'b000100);
      end
      4'd3: begin a = 1'b1; b = 2'b10; end
      4'd4: begin rd = 1'b1; iod = 1'b1; end
      4'd5: begin wreg = 1'b1; m2r = 1'b1; end
      4'd6: begin wr = 1'b1; iod = 1'b1; end
      4'd7: begin a = 1'b1; aop = 2'b10; end
      4'd8: begin wreg = 1'b1; rdst = 1'b1; end
      4'd9: begin a = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
`ifdef CONTROL_SALTO_J_EN
      4'd10: begin pc = 1'b1; psrc = 2'b10; end
`endif
      default: ;
    endcase
    return {pc, pcc, iod, rd, wr, ir, m2r, rdst, wreg, a, b, aop, psrc, ilg};
  endfunction

  initial begin
    exp_t e;

    // lw from reset release: 0,1,2,3,4,5
    add_vec(6'b100011, 1'b1, 4'd0);
    add_vec(6'b100011, 1'b1, 4'd1);
    add_vec(6'b100011, 1'b1, 4'd2);
    add_vec(6'b100011, 1'b1, 4'd3);
    add_vec(6'b100011, 1'b1, 4'd4);
    add_vec(6'b100011, 1'b1, 4'd5);
    // R-type: 1,2,7,8
    add_vec(6'b000000, 1'b1, 4'd1);
    add_vec(6'b000000, 1'b1, 4'd2);
    add_vec(6'b000000, 1'b1, 4'd7);
    add_vec(6'b000000, 1'b1, 4'd8);
    // beq: 1,2,9
    add_vec(6'b000100, 1'b1, 4'd1);
    add_vec(6'b000100, 1'b1, 4'd2);
    add_vec(6'b000100, 1'b1, 4'd9);
    // sw with three not-ready cycles: 1,2,3,6,6,6,6
    add_vec(6'b101011, 1'b1, 4'd1);
    add_vec(6'b101011, 1'b1, 4'd2);
    add_vec(6'b101011, 1'b1, 4'd3);
    add_vec(6'b101011, 1'b0, 4'd6);
    add_vec(6'b101011, 1'b0, 4'd6);
    add_vec(6'b101011, 1'b0, 4'd6);
    add_vec(6'b101011, 1'b1, 4'd6);
    // illegal opcode: 1,2 (pulse)
    add_vec(6'b111111, 1'b1, 4'd1);
    add_vec(6'b111111, 1'b1, 4'd2);
    // j, with a stalled fetch first
    add_vec(6'b000010, 1'b0, 4'd1);
    add_vec(6'b000010, 1'b1, 4'd1);
    add_vec(6'b000010, 1'b1, 4'd2);
`ifdef CONTROL_SALTO_J_EN
    add_vec(6'b100011, 1'b1, 4'd10);
`else
    add_vec(6'b100011, 1'b0, 4'd1);
`endif
    // lw stalled in LEERMEM, left there for the reset test
    add_vec(6'b100011, 1'b1, 4'd1);
    add_vec(6'b100011, 1'b1, 4'd2);
    add_vec(6'b100011, 1'b1, 4'd3);
    add_vec(6'b100011, 1'b0, 4'd4);
    add_vec(6'b100011, 1'b0, 4'd4);

    // Reset held across edges with active-looking inputs.
    rst_n    = 1'b0;
    instru   = 6'b100011;
    MemListo = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_estado", {28'd0, Estado}, 32'd0);
    check("reset_outs", {15'd0, dut_outs}, 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      instru   = vecs[i].instru;
      MemListo = vecs[i].ml;
      e.idx  = i;
      e.est  = vecs[i].est;
      e.outs = model_outs(vecs[i].est, vecs[i].ml, vecs[i].instru);
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d_scoreboard_empty", i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_estado", e.idx), {28'd0, Estado}, {28'd0, e.est});
        check($sformatf("v%0d_outs", e.idx), {15'd0, dut_outs}, {15'd0, e.outs});
      end
      @(posedge clk);
      #1;
    end

    // Still waiting in LEERMEM; drop reset between edges.
    check("stall_estado", {28'd0, Estado}, 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_estado", {28'd0, Estado}, 32'd0);
    check("async_reset_outs", {15'd0, dut_outs}, 32'd0);

    @(posedge clk);
    #1;
    check("reset_held_estado", {28'd0, Estado}, 32'd0);
    rst_n    = 1'b1;
    MemListo = 1'b1;
    @(negedge clk);
    check("release_estado0", {28'd0, Estado}, 32'd0);
    check("release_outs0", {15'd0, dut_outs}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("release_estado1", {28'd0, Estado}, 32'd1);
    check("release_outs1", {15'd0, dut_outs},
          {15'd0, model_outs(4'd1, 1'b1, instru)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
